ram_word_access_ctrl: RTL and testbench

- Sequencer between the CPU datapath and the byte-wide 256x8 RAM (ram256x8).
- Accepts one byte, halfword or word read/write request at a time.
- Breaks each request into single-byte RAM accesses, driving the RAM's Enable/ReadWrite/Address/DataIn and assembling bytes from DataOut.
- Returns a one-cycle Done (memory-function-complete) pulse to the control unit.

---
 rtl/ram_word_access_ctrl_if.sv | 31 +++
 rtl/ram_word_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_ram_word_access_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ram_word_access_ctrl_if.sv
// Request/response bus between the CPU datapath and the word-access sequencer,
// plus the byte-wide RAM port the sequencer drives.
interface ram_word_access_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  rw;
  logic [1:0]            size;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  mem_enable;
  logic                  mem_read_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [7:0]            mem_data_in;
  logic [7:0]            mem_data_out;

  // master = CPU side together with the RAM; slave = the sequencer
  modport master (
    output start, rw, size, addr, wdata, mem_data_out,
    input  rdata, busy, done, err, mem_enable, mem_read_write, mem_address, mem_data_in
  );

  modport slave (
    input  start, rw, size, addr, wdata, mem_data_out,
    output rdata, busy, done, err, mem_enable, mem_read_write, mem_address, mem_data_in
  );
endinterface

// File: rtl/ram_word_access_ctrl.sv
// Splits byte/halfword/word requests into single-byte accesses on a 256x8 RAM,
// assembling read bytes and returning a one-cycle done (with err on bad requests).
//
// state  | meaning
// IDLE   | waiting for start; request fields latched here
// SETUP  | address/data/direction presented, enable low
// STROBE | enable high for one cycle, read byte captured at the end
// DONE   | done pulse (err on illegal request), rdata updated on reads
module ram_word_access_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram_word_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state;
  logic                  rw_q;
  logic [1:0]            last_q;
  logic [1:0]            idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q;

  logic [1:0]            req_last;
  logic                  req_bad;
  logic [1:0]            idx_nxt;
  logic [31:0]           asm_nxt;

  // Byte lane of transfer i inside an (last+1)-byte value.
  function automatic logic [1:0] lane_of(input logic [1:0] last, input logic [1:0] i);
    logic [1:0] lane;
    lane = BIG_ENDIAN ? (last - i) : i;
    return lane;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  always_comb begin
    req_last = 2'd0;
    req_bad  = 1'b0;
    case (bus.size)
      2'b00: req_last = 2'd0;
      2'b01: begin
        req_last = 2'd1;
        req_bad  = bus.addr[0];
      end
      2'b10: begin
        req_last = 2'd3;
        req_bad  = |bus.addr[1:0];
      end
      default: req_bad = 1'b1;
    endcase
  end

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{lane_of(last_q, idx_q), 3'b000} +: 8] = bus.mem_data_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      rw_q               <= 1'b1;
      last_q             <= 2'd0;
      idx_q              <= 2'd0;
      addr_q             <= '0;
      wdata_q            <= 32'd0;
      asm_q              <= 32'd0;
      bus.rdata          <= 32'd0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.err            <= 1'b0;
      bus.mem_enable     <= 1'b0;
      bus.mem_read_write <= 1'b1;
      bus.mem_address    <= '0;
      bus.mem_data_in    <= 8'd0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rw_q     <= bus.rw;
            last_q   <= req_last;
            idx_q    <= 2'd0;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            asm_q    <= 32'd0;
            bus.busy <= 1'b1;
            if (req_bad) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else begin
              state              <= SETUP;
              bus.mem_address    <= bus.addr;
              bus.mem_read_write <= bus.rw;
              bus.mem_data_in    <= byte_of(bus.wdata, lane_of(req_last, 2'd0));
            end
          end
        end
        SETUP: begin
          state          <= STROBE;
          bus.mem_enable <= 1'b1;
        end
        STROBE: begin
          // Enable always drops here, so consecutive accesses get a low cycle between them.
          bus.mem_enable <= 1'b0;
          if (rw_q) asm_q <= asm_nxt;
          if (idx_q == last_q) begin
            state              <= DONE;
            bus.done           <= 1'b1;
            bus.mem_read_write <= 1'b1;
            if (rw_q) bus.rdata <= asm_nxt;
          end else begin
            state           <= SETUP;
            idx_q           <= idx_nxt;
            bus.mem_address <= addr_q + ADDR_WIDTH'(idx_nxt);
            bus.mem_data_in <= byte_of(wdata_q, lane_of(last_q, idx_nxt));
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_access_ctrl.sv
// Bench for ram_word_access_ctrl: big- and little-endian instances run in lock-step
// against behavioural 256x8 RAMs, with a scoreboard of expected completions.
module tb_ram_word_access_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_word_access_ctrl_if #(.ADDR_WIDTH(8)) bus_be ();
  ram_word_access_ctrl_if #(.ADDR_WIDTH(8)) bus_le ();

  ram_word_access_ctrl #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset_n(reset_n), .bus(bus_be)
  );
  ram_word_access_ctrl #(.ADDR_WIDTH(8), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset_n(reset_n), .bus(bus_le)
  );

  logic [7:0] mem_be [0:255];
  logic [7:0] mem_le [0:255];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [7:0] pl_data = 8'd0;

  assign bus_be.mem_data_out = mem_be[bus_be.mem_address];
  assign bus_le.mem_data_out = mem_le[bus_le.mem_address];

  always @(posedge clk) begin
    if (pl_we) mem_be[pl_addr] <= pl_data;
    else if (bus_be.mem_enable && !bus_be.mem_read_write) mem_be[bus_be.mem_address] <= bus_be.mem_data_in;
  end
  always @(posedge clk) begin
    if (pl_we) mem_le[pl_addr] <= pl_data;
    else if (bus_le.mem_enable && !bus_le.mem_read_write) mem_le[bus_le.mem_address] <= bus_le.mem_data_in;
  end

  typedef struct {
    string       tag;
    logic [31:0] rd_be;
    logic [31:0] rd_le;
    logic        err;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic start, input logic rw, input logic [1:0] size,
                         input logic [7:0] addr, input logic [31:0] wdata);
    bus_be.start = start; bus_be.rw = rw; bus_be.size = size; bus_be.addr = addr; bus_be.wdata = wdata;
    bus_le.start = start; bus_le.rw = rw; bus_le.size = size; bus_le.addr = addr; bus_le.wdata = wdata;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_req(input string tag, input logic rw, input logic [1:0] size,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd_be, input logic [31:0] rd_le,
                         input logic err, input int lat, input int pulses, input bit spam);
    exp_t e;
    exp_t g;
    int   npulse;
    bit   prev_en;
    bit   seen;
    e.tag = tag; e.rd_be = rd_be; e.rd_le = rd_le; e.err = err; e.lat = lat; e.pulses = pulses;
    sb.push_back(e);
    set_req(1'b1, rw, size, addr, wdata);
    @(posedge clk);
    npulse = 0; prev_en = 1'b0; seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      bus_be.start = spam && cyc <= 8;
      bus_le.start = spam && cyc <= 8;
      if (bus_be.mem_enable && !prev_en) begin
        check({tag, " addr"}, {24'd0, bus_be.mem_address}, {24'd0, addr + 8'(npulse)});
        check({tag, " memrw"}, {31'd0, bus_be.mem_read_write}, {31'd0, rw});
        npulse++;
      end
      prev_en = bus_be.mem_enable;
      if (bus_be.done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check({tag, " unexpected done"}, 32'd1, 32'd0);
        end else begin
          g = sb.pop_front();
          check({g.tag, " latency"}, 32'(cyc), 32'(g.lat));
          check({g.tag, " rdata be"}, bus_be.rdata, g.rd_be);
          check({g.tag, " rdata le"}, bus_le.rdata, g.rd_le);
          check({g.tag, " err"}, {31'd0, bus_be.err}, {31'd0, g.err});
          check({g.tag, " le done"}, {31'd0, bus_le.done}, 32'd1);
          check({g.tag, " pulses"}, 32'(npulse), 32'(g.pulses));
        end
      end
    end
    if (!seen) check({tag, " done timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, " busy low"}, {31'd0, bus_be.busy}, 32'd0);
    if (spam) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({tag, " no extra done"}, {31'd0, bus_be.done}, 32'd0);
        check({tag, " no extra enable"}, {31'd0, bus_be.mem_enable}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(1'b0, 1'b1, 2'b00, 8'd0, 32'd0);
    @(negedge clk);
    check("reset rdata", bus_be.rdata, 32'd0);
    check("reset busy", {31'd0, bus_be.busy}, 32'd0);
    check("reset done", {31'd0, bus_be.done}, 32'd0);
    check("reset err", {31'd0, bus_be.err}, 32'd0);
    check("reset mem_enable", {31'd0, bus_be.mem_enable}, 32'd0);
    check("reset mem_read_write", {31'd0, bus_be.mem_read_write}, 32'd1);
    check("reset mem_address", {24'd0, bus_be.mem_address}, 32'd0);

    for (int a = 0; a < 256; a++) preload(8'(a), 8'h00);
    preload(8'd0, 8'hE3); preload(8'd1, 8'hA0); preload(8'd2, 8'h10); preload(8'd3, 8'h05);
    preload(8'd252, 8'h11); preload(8'd253, 8'h22); preload(8'd254, 8'h33); preload(8'd255, 8'h44);

    reset_n = 1'b1;
    @(negedge clk);

    run_req("word rd 0", 1'b1, 2'b10, 8'd0, 32'd0, 32'hE3A01005, 32'h0510A0E3, 1'b0, 9, 4, 1'b0);
    run_req("byte rd 2", 1'b1, 2'b00, 8'd2, 32'd0, 32'h00000010, 32'h00000010, 1'b0, 3, 1, 1'b0);
    run_req("half rd 2", 1'b1, 2'b01, 8'd2, 32'd0, 32'h00001005, 32'h00000510, 1'b0, 5, 2, 1'b0);
    run_req("word wr 8", 1'b0, 2'b10, 8'd8, 32'hDEADBEEF, 32'h00001005, 32'h00000510, 1'b0, 9, 4, 1'b0);
    check("mem be 8", {24'd0, mem_be[8]}, 32'hDE);
    check("mem be 9", {24'd0, mem_be[9]}, 32'hAD);
    check("mem be 10", {24'd0, mem_be[10]}, 32'hBE);
    check("mem be 11", {24'd0, mem_be[11]}, 32'hEF);
    check("mem le 8", {24'd0, mem_le[8]}, 32'hEF);
    check("mem le 11", {24'd0, mem_le[11]}, 32'hDE);
    run_req("word rd 8", 1'b1, 2'b10, 8'd8, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 9, 4, 1'b0);
    run_req("word rd 6 bad", 1'b1, 2'b10, 8'd6, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1, 0, 1'b0);
    run_req("size 11 bad", 1'b1, 2'b11, 8'd0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1, 0, 1'b0);
    run_req("half wr 1 bad", 1'b0, 2'b01, 8'd1, 32'h1234, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1, 0, 1'b0);
    check("bad write no mem change", {24'd0, mem_be[1]}, 32'hA0);
    run_req("word rd 252", 1'b1, 2'b10, 8'd252, 32'd0, 32'h11223344, 32'h44332211, 1'b0, 9, 4, 1'b0);
    run_req("word rd 0 spam", 1'b1, 2'b10, 8'd0, 32'd0, 32'hE3A01005, 32'h0510A0E3, 1'b0, 9, 4, 1'b1);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    // Word write to 16, reset pulled during the STROBE of byte 1 (cycle 4).
    set_req(1'b1, 1'b0, 2'b10, 8'd16, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 2'b10, 8'd16, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre-reset enable high", {31'd0, bus_be.mem_enable}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async reset enable", {31'd0, bus_be.mem_enable}, 32'd0);
    check("async reset busy", {31'd0, bus_be.busy}, 32'd0);
    check("async reset le enable", {31'd0, bus_le.mem_enable}, 32'd0);
    check("async reset rdata", bus_be.rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mem be 16 written", {24'd0, mem_be[16]}, 32'hDE);
    check("mem be 17 unwritten", {24'd0, mem_be[17]}, 32'h00);
    check("mem be 18 unwritten", {24'd0, mem_be[18]}, 32'h00);
    check("mem be 19 unwritten", {24'd0, mem_be[19]}, 32'h00);
    check("mem le 16 written", {24'd0, mem_le[16]}, 32'hEF);
    check("mem le 18 unwritten", {24'd0, mem_le[18]}, 32'h00);
    reset_n = 1'b1;
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b00, 8'd0, 32'd0);
    run_req("byte rd 2 after reset", 1'b1, 2'b00, 8'd2, 32'd0, 32'h00000010, 32'h00000010, 1'b0, 3, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
